// File: rtl/ff_common_pkg.sv
// ----------------------------------------------------------------------------
// ff_common_pkg
// Definitions shared by the push-button front end and the T flip-flop blocks.
//   dbt_state_e          : 2-bit debounce FSM state. The encodings follow Gray
//                          order, so each transition changes only one bit.
//   DEF_SYNC_STAGES      : default synchronizer depth
//   DEF_DEBOUNCE_CYCLES  : default number of stable cycles needed to accept
//                          a level change
//   DEF_CNT_W            : default width of the press counter
// ----------------------------------------------------------------------------
package ff_common_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      ARM_HIGH  = 2'b01,
      IDLE_HIGH = 2'b11,
      ARM_LOW   = 2'b10
   } dbt_state_e;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/debounce_toggle_gen_if.sv
// ----------------------------------------------------------------------------
// debounce_toggle_gen_if
// Groups the button-side signals of debounce_toggle_gen.
//   btn_raw     : raw button input. It is asynchronous to clk.
//   enable      : gates t_pulse and press_count
//   level       : debounced button level
//   rise_pulse  : one-cycle pulse on an accepted 0->1 change
//   fall_pulse  : one-cycle pulse on an accepted 1->0 change
//   t_pulse     : rise_pulse gated by enable; it feeds a T flip-flop
//   press_count : count of enabled accepted presses; it wraps
// Modports:
//   master : the side that drives the button and the enable, and observes
//            the results
//   slave  : the debouncer
// ----------------------------------------------------------------------------
interface debounce_toggle_gen_if
   import ff_common_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             btn_raw;
   logic             enable;
   logic             level;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             t_pulse;
   logic [CNT_W-1:0] press_count;

   modport master (
      output btn_raw, enable,
      input  level, rise_pulse, fall_pulse, t_pulse, press_count
   );

   modport slave (
      input  btn_raw, enable,
      output level, rise_pulse, fall_pulse, t_pulse, press_count
   );
endinterface

// File: rtl/bit_synchronizer.sv
// ----------------------------------------------------------------------------
// bit_synchronizer
// A plain flop chain that brings an asynchronous single-bit input into the
// clk domain. No logic sits between the stages.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset. It clears every stage to 0.
//   d     : asynchronous input
//   q     : synchronized output, taken from the last stage
// STAGES must be 2 or more.
// ----------------------------------------------------------------------------
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/debounce_toggle_gen.sv
// ----------------------------------------------------------------------------
// debounce_toggle_gen
// This is the push-button front end for a T flip-flop. It does three things:
//   1. It synchronizes btn_raw.
//   2. It debounces the synchronized level with a counter FSM.
//   3. It emits registered rise and fall pulses, a t_pulse gated by enable,
//      and a wrapping count of the enabled presses.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : button-side signals (see debounce_toggle_gen_if, slave modport)
// Timing: when btn_raw is stable from before edge 1, level and the pulse
// update on edge SYNC_STAGES + DEBOUNCE_CYCLES.
// ----------------------------------------------------------------------------
module debounce_toggle_gen
   import ff_common_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input logic                 clk,
   input logic                 rst_n,
   debounce_toggle_gen_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic             s;
   dbt_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic             level_q;
   logic             rise_q;
   logic             fall_q;
   logic             t_q;
   logic [CNT_W-1:0] press_count_q;
   logic [CNT_W-1:0] press_count_d;
   logic             cnt_last;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.btn_raw),
      .q     (s)
   );

   // An ARM state enters with cnt=1, so the change is accepted on the cycle
   // in which cnt+1 reaches DEBOUNCE_CYCLES.
   assign cnt_last      = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
   assign press_count_d = press_count_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE_LOW;
         cnt_q         <= '0;
         level_q       <= 1'b0;
         rise_q        <= 1'b0;
         fall_q        <= 1'b0;
         t_q           <= 1'b0;
         press_count_q <= '0;
      end else begin
         // The pulses default low, so each one lasts exactly one cycle.
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         t_q    <= 1'b0;
         case (state_q)
            IDLE_LOW: begin
               if (s) begin
                  state_q <= ARM_HIGH;
                  cnt_q   <= CW'(1);
               end
            end
            ARM_HIGH: begin
               if (!s) begin
                  state_q <= IDLE_LOW;
                  cnt_q   <= '0;
               end else if (cnt_last) begin
                  state_q <= IDLE_HIGH;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
                  // Only the enable value at the acceptance edge matters.
                  t_q     <= bus.enable;
                  if (bus.enable) begin
                     press_count_q <= press_count_d;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            IDLE_HIGH: begin
               if (!s) begin
                  state_q <= ARM_LOW;
                  cnt_q   <= CW'(1);
               end
            end
            ARM_LOW: begin
               if (s) begin
                  state_q <= IDLE_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_last) begin
                  state_q <= IDLE_LOW;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.level       = level_q;
   assign bus.rise_pulse  = rise_q;
   assign bus.fall_pulse  = fall_q;
   assign bus.t_pulse     = t_q;
   assign bus.press_count = press_count_q;
endmodule

// File: tb/tb_debounce_toggle_gen.sv
// ----------------------------------------------------------------------------
// tb_debounce_toggle_gen
// Directed bench for debounce_toggle_gen, using the default parameters.
// Each press or release that should be accepted pushes an expected pulse
// into a queue. The expected pulse holds the kind, the cycle, the level,
// t_pulse and press_count. A negedge monitor pops one entry for every
// pulse the DUT produces.
// ----------------------------------------------------------------------------
module tb_debounce_toggle_gen;
   localparam int LAT = 6;  // SYNC_STAGES + DEBOUNCE_CYCLES

   typedef struct {
      bit         rise;
      int         cyc;
      bit         lvl;
      bit         t;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic       rst_n;
   int         cyc;
   int         n_checks;
   int         n_fail;
   logic [7:0] model_count;
   logic       tff_q;
   logic       tff_before;
   exp_t       sb[$];

   debounce_toggle_gen_if #(.CNT_W(8)) bus ();

   debounce_toggle_gen #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // This models the T flip-flop wired to t_pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tff_q <= 1'b0;
      else if (bus.t_pulse) tff_q <= ~tff_q;
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(bit rise, int at, bit lvl, bit t, logic [7:0] cnt);
      exp_t e;
      e.rise = rise; e.cyc = at; e.lvl = lvl; e.t = t; e.cnt = cnt;
      sb.push_back(e);
   endtask

   // A clean press followed by a clean release. It is called just after a
   // posedge, and hold must be at least 4.
   task automatic press_release(int hold);
      bus.btn_raw = 1'b1;
      if (bus.enable) model_count = model_count + 8'd1;
      push(1'b1, cyc + LAT, 1'b1, bus.enable, model_count);
      step(hold);
      bus.btn_raw = 1'b0;
      push(1'b0, cyc + LAT, 1'b0, 1'b0, model_count);
      step(LAT + 1);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n === 1'b1 && (bus.rise_pulse || bus.fall_pulse)) begin
         check("pulse_overlap", {31'd0, bus.rise_pulse & bus.fall_pulse}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, bus.rise_pulse, bus.fall_pulse}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_kind",  {31'd0, bus.rise_pulse}, {31'd0, e.rise});
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_level", {31'd0, bus.level}, {31'd0, e.lvl});
            check("pulse_t",     {31'd0, bus.t_pulse}, {31'd0, e.t});
            check("pulse_count", {24'd0, bus.press_count}, {24'd0, e.cnt});
         end
      end else if (rst_n === 1'b1 && bus.t_pulse) begin
         check("t_without_rise", {31'd0, bus.t_pulse}, 32'd0);
      end
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      model_count = 8'd0;
      bus.btn_raw = 1'b1;
      bus.enable  = 1'b1;
      rst_n       = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      // 1. The outputs must clear asynchronously, before any clock edge.
      check("rst_level", {31'd0, bus.level}, 32'd0);
      check("rst_rise",  {31'd0, bus.rise_pulse}, 32'd0);
      check("rst_fall",  {31'd0, bus.fall_pulse}, 32'd0);
      check("rst_t",     {31'd0, bus.t_pulse}, 32'd0);
      check("rst_count", {24'd0, bus.press_count}, 32'd0);
      step(3);
      bus.btn_raw = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(3);

      // 2. A clean press is accepted on edge 6.
      bus.btn_raw = 1'b1;
      model_count = model_count + 8'd1;
      push(1'b1, cyc + LAT, 1'b1, 1'b1, model_count);
      step(12);
      check("press_level", {31'd0, bus.level}, 32'd1);
      check("press_count", {24'd0, bus.press_count}, 32'd1);

      // 4. A release gives a fall pulse, and the count is unchanged.
      bus.btn_raw = 1'b0;
      push(1'b0, cyc + LAT, 1'b0, 1'b0, model_count);
      step(12);
      check("release_level", {31'd0, bus.level}, 32'd0);
      check("release_count", {24'd0, bus.press_count}, 32'd1);

      // 3. A 3-cycle pulse is rejected. A 4-cycle pulse is accepted once.
      bus.btn_raw = 1'b1;
      step(3);
      bus.btn_raw = 1'b0;
      step(10);
      check("bounce_level", {31'd0, bus.level}, 32'd0);
      check("bounce_count", {24'd0, bus.press_count}, 32'd1);
      press_release(4);
      check("four_high_count", {24'd0, bus.press_count}, {24'd0, model_count});

      // 5. With enable=0 the rise pulse still fires, but it is not counted
      // and does not toggle.
      tff_before = tff_q;
      bus.enable = 1'b0;
      press_release(6);
      check("gated_count", {24'd0, bus.press_count}, {24'd0, model_count});
      check("gated_tff", {31'd0, tff_q}, {31'd0, tff_before});
      bus.enable = 1'b1;
      press_release(6);
      check("enabled_count", {24'd0, bus.press_count}, {24'd0, model_count});
      check("enabled_tff", {31'd0, tff_q}, {31'd0, ~tff_before});

      // 6a. press_count wraps from 255 to 0.
      while (model_count != 8'd255) press_release(6);
      check("count_255", {24'd0, bus.press_count}, 32'd255);
      press_release(6);
      check("count_wrap", {24'd0, bus.press_count}, 32'd0);
      press_release(6);
      check("count_after_wrap", {24'd0, bus.press_count}, 32'd1);

      // 6b. Reset is asserted during ARM_HIGH. The button stays held across
      // the release of reset.
      bus.btn_raw = 1'b1;
      step(4);
      #2 rst_n = 1'b0;
      #1;
      check("midarm_level", {31'd0, bus.level}, 32'd0);
      check("midarm_rise",  {31'd0, bus.rise_pulse}, 32'd0);
      check("midarm_count", {24'd0, bus.press_count}, 32'd0);
      model_count = 8'd0;
      step(2);
      rst_n = 1'b1;
      model_count = 8'd1;
      push(1'b1, cyc + LAT, 1'b1, 1'b1, model_count);
      step(10);
      check("held_count", {24'd0, bus.press_count}, 32'd1);
      bus.btn_raw = 1'b0;
      push(1'b0, cyc + LAT, 1'b0, 1'b0, model_count);
      step(12);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
